regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Multi-cycle controller for the 8x8-bit register file. Accepts 16-bit instructions over a valid/ready
//  handshake and drives the SA/SB read selects and the DS/Load/Ddata write port. Contains an 8-bit ALU
//  (ADD/SUB/AND/OR/XOR/MOV/LDI), zero/carry flags and a retired-instruction counter.
//  Sits between the instruction source and the register file.
// PARAMETERS
//  DATA_W   8   register/ALU data width; the register file is fixed at 8 bits, so DATA_W must stay 8
//  CNT_W    8   retired-instruction counter width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  instr_valid  in   1       instruction offered
//  instr        in   16      [15:12] op, [11:9] ds, [8:6] sa, [5:3] sb, [7:0] imm (LDI only)
//  instr_ready  out  1       sequencer accepts instr this cycle
//  SA           out  3       register file read select A
//  SB           out  3       register file read select B
//  Adata        in   8       register file read data A (combinational from SA)
//  Bdata        in   8       register file read data B (combinational from SB)
//  DS           out  3       register file write select
//  Load         out  1       register file write enable (one-cycle pulse)
//  Ddata        out  8       register file write data
//  busy         out  1       state != IDLE
//  halted       out  1       HALT executed; sticky until rst
//  illegal      out  1       unknown opcode seen; sticky until rst
//  zero, carry  out  1 each  ALU flags
//  retired      out  CNT_W   count of completed instructions
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; all outputs 0 except instr_ready=1.
//   - rst has priority over every event. Asserted mid-instruction it aborts: no Load pulse and no
//     flag or counter update.
//  Opcodes:
//   - 0 NOP, 1 LDI (R[ds]=imm), 2 MOV (R[ds]=R[sa]), 3 ADD, 4 SUB (R[sa]-R[sb]), 5 AND, 6 OR, 7 XOR,
//     8 HALT.
//   - 9-15 are illegal: set illegal, execute as NOP.
//  States: IDLE -> EXEC -> WB -> IDLE; HALT.
//   - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to EXEC.
//   - EXEC: SA/SB driven from the latched instr. Result (9-bit for ADD/SUB) registered from
//     Adata/Bdata. Next state is WB; for op 8 it is HALT.
//   - WB: Load=1 for ops 1-7, DS=ds, Ddata=result; Load=0 for NOP/illegal. retired+=1 (wraps
//     modulo 2^CNT_W). Go to IDLE.
//   - HALT: halted=1, instr_ready=0, Load=0. Exit only on rst. HALT itself does not increment retired.
//  Timing and hazards:
//   - Accept at cycle N -> Load at N+2 -> instr_ready again at N+3.
//   - Throughput: one instruction per 3 cycles.
//   - No read-after-write hazard: the next EXEC (>= N+4) sees the written value.
//  Arithmetic:
//   - ADD: carry=bit 8 of A+B.
//   - SUB: carry=borrow (1 iff A<B unsigned), result mod 256.
//   - AND/OR/XOR clear carry.
//   - zero=(result==0).
//   - Flags update in WB for ops 3-7 only; LDI/MOV/NOP leave them unchanged.
//  Handshake:
//   - instr is sampled only in IDLE.
//   - instr_valid while busy is ignored; the source must hold the instr until accepted.
//  Outputs:
//   - SA, SB and DS hold their last values outside EXEC/WB.
//   - Load is 1 only in WB.
// TESTING
//  1 Reset, then LDI R1,0x05; LDI R2,0x03 -> Load pulses at N+2 with DS=1, Ddata=05 and DS=2,
//    Ddata=03; retired=2.
//  2 ADD R3=R1+R2 (0xFF+0x01) -> Ddata=0x00, zero=1, carry=1. SUB R4=R2-R1 (3-5) -> Ddata=0xFE,
//    carry=1, zero=0.
//  3 instr_valid held high with back-to-back instrs -> instr_ready high only every 3rd cycle; no
//    instruction lost or duplicated.
//  4 opcode 0xB -> illegal=1, no Load, retired+1. HALT -> halted=1, instr_ready=0 until rst.
//  5 rst asserted during EXEC of ADD -> no Load next cycle, flags/retired unchanged, instr_ready=1
//    after rst.
//  6 256 NOPs with CNT_W=8 -> retired wraps 0xFF->0x00; Load never asserted.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Multi-cycle controller for an 8x8 register file: IDLE -> EXEC -> WB.
// 8-bit ALU with zero/carry flags, sticky halt/illegal and retire count.
module regfile_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [2:0]        SA,
  output logic [2:0]        SB,
  input  logic [DATA_W-1:0] Adata,
  input  logic [DATA_W-1:0] Bdata,
  output logic [2:0]        DS,
  output logic              Load,
  output logic [DATA_W-1:0] Ddata,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic              zero,
  output logic              carry,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_instr;
  logic [DATA_W:0]   r_result;
  logic              r_zero;
  logic              r_carry;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_retired;

  logic [3:0]        w_op;
  logic              w_accept;
  logic              w_wr_op;
  logic              w_flag_op;
  logic [DATA_W:0]   w_alu;

  assign w_op      = r_instr[15:12];
  assign w_accept  = instr_valid && (r_state == S_IDLE);
  assign w_wr_op   = (w_op >= 4'd1) && (w_op <= 4'd7);
  assign w_flag_op = (w_op >= 4'd3) && (w_op <= 4'd7);

  // 9-bit result: bit DATA_W is carry for ADD and borrow for SUB
  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd1:    w_alu = {1'b0, r_instr[DATA_W-1:0]};
      4'd2:    w_alu = {1'b0, Adata};
      4'd3:    w_alu = {1'b0, Adata} + {1'b0, Bdata};
      4'd4:    w_alu = {1'b0, Adata} - {1'b0, Bdata};
      4'd5:    w_alu = {1'b0, Adata & Bdata};
      4'd6:    w_alu = {1'b0, Adata | Bdata};
      4'd7:    w_alu = {1'b0, Adata ^ Bdata};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_next = S_EXEC;
      S_EXEC:  w_next = (w_op == 4'd8) ? S_HALT : S_WB;
      S_WB:    w_next = S_IDLE;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    Load        = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      S_WB:    Load   = w_wr_op;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_accept)
        r_instr <= instr;
      if (r_state == S_EXEC)
        r_result <= w_alu;
      if (r_state == S_WB) begin
        r_retired <= r_retired + CNT_W'(1);
        if (w_flag_op) begin
          r_zero  <= (r_result[DATA_W-1:0] == '0);
          r_carry <= r_result[DATA_W];
        end
        if (w_op >= 4'd9)
          r_illegal <= 1'b1;
      end
    end
  end

  // Selects come straight from the latched instruction, so they hold between ops
  assign SA      = r_instr[8:6];
  assign SB      = r_instr[5:3];
  assign DS      = r_instr[11:9];
  assign Ddata   = r_result[DATA_W-1:0];
  assign zero    = r_zero;
  assign carry   = r_carry;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register file model, spec-level
// reference model checked every cycle, plus directed literal checks.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  SA, SB, DS;
  logic [7:0]  Adata, Bdata, Ddata;
  logic        Load, busy, halted, illegal, zero, carry;
  logic [7:0]  retired;

  int checks = 0;
  int errors = 0;

  regfile_sequencer #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready),
    .SA(SA), .SB(SB),
    .Adata(Adata), .Bdata(Bdata),
    .DS(DS), .Load(Load), .Ddata(Ddata),
    .busy(busy), .halted(halted), .illegal(illegal),
    .zero(zero), .carry(carry), .retired(retired)
  );

  initial forever #5 clk = ~clk;

  // Register file driven by the DUT
  logic [7:0] rf [8];
  assign Adata = rf[SA];
  assign Bdata = rf[SB];
  always @(posedge clk) if (Load) rf[DS] <= Ddata;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  function automatic logic [8:0] calc(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] imm);
    case (op)
      4'd1:    return {1'b0, imm};
      4'd2:    return {1'b0, a};
      4'd3:    return 9'(a) + 9'(b);
      4'd4:    return 9'(a) - 9'(b);
      4'd5:    return {1'b0, a & b};
      4'd6:    return {1'b0, a | b};
      4'd7:    return {1'b0, a ^ b};
      default: return 9'd0;
    endcase
  endfunction

  // Reference model: one instruction in flight, accepted at cycle pt
  int          cyc = 0;
  int          pt = 0;
  bit          pend = 0;
  bit          armed = 0;
  logic [15:0] pi = '0;
  logic [7:0]  mrf [8];
  bit          mz = 0, mc = 0, mhalt = 0, mill = 0;
  logic [7:0]  mret = '0;

  always @(posedge clk) begin
    logic [3:0] op;
    logic [8:0] r;
    op = pi[15:12];
    if (rst) begin
      pend = 0; mz = 0; mc = 0; mret = '0;
      mhalt = 0; mill = 0; armed = 1;
    end else if (armed) begin
      if (pend && cyc == pt + 1 && op == 4'd8) begin
        mhalt = 1;
        pend = 0;
      end else if (pend && cyc == pt + 2) begin
        r = calc(op, mrf[pi[8:6]], mrf[pi[5:3]], pi[7:0]);
        if (op >= 1 && op <= 7) mrf[pi[11:9]] = r[7:0];
        if (op >= 3 && op <= 7) begin
          mz = (r[7:0] == 8'd0);
          mc = r[8];
        end
        if (op >= 9) mill = 1;
        mret = mret + 8'd1;
        pend = 0;
      end else if (!pend && !mhalt && instr_valid) begin
        pend = 1;
        pt = cyc;
        pi = instr;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit   er, el;
    logic [3:0] op;
    if (armed) begin
      op = pi[15:12];
      er = !mhalt && !pend;
      el = pend && cyc == pt + 2 && op >= 1 && op <= 7;
      chk("ready", 16'(instr_ready), 16'(er));
      chk("busy", 16'(busy), 16'(!er));
      chk("load", 16'(Load), 16'(el));
      chk("halted", 16'(halted), 16'(mhalt));
      chk("illegal", 16'(illegal), 16'(mill));
      chk("zero", 16'(zero), 16'(mz));
      chk("carry", 16'(carry), 16'(mc));
      chk("retired", 16'(retired), 16'(mret));
      if (el) begin
        chk("ds", 16'(DS), 16'(pi[11:9]));
        chk("ddata", 16'(Ddata),
            16'(calc(op, mrf[pi[8:6]], mrf[pi[5:3]], pi[7:0]) & 9'h0FF));
      end
      if (pend && cyc == pt + 1) begin
        chk("sa", 16'(SA), 16'(pi[8:6]));
        chk("sb", 16'(SB), 16'(pi[5:3]));
      end
    end
  end

  function automatic logic [15:0] ldi(input int d, input logic [7:0] imm);
    return {4'd1, 3'(d), 1'b0, imm};
  endfunction

  function automatic logic [15:0] alu(input int op, input int d, input int a, input int b);
    return {4'(op), 3'(d), 3'(a), 3'(b), 3'd0};
  endfunction

  task automatic send(input logic [15:0] w, input bit keep);
    bit got;
    int k;
    got = 0;
    k = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!got && k < 20) begin
      @(negedge clk);
      if (instr_ready) got = 1;
      else k++;
    end
    @(posedge clk);
    #1;
    if (!keep) instr_valid = 1'b0;
    chk("accept_timeout", 16'(got), 16'd1);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i]  = 8'd0;
      mrf[i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sa", 16'(SA), 16'd0);
    chk("rst_ds", 16'(DS), 16'd0);
    chk("rst_ddata", 16'(Ddata), 16'd0);
    chk("rst_ready", 16'(instr_ready), 16'd1);
    @(posedge clk); #1;

    send(ldi(1, 8'h05), 0);
    send(ldi(2, 8'h03), 0);
    idle(2);
    chk("t1_ret", 16'(retired), 16'h02);
    chk("t1_r1", 16'(rf[1]), 16'h05);
    chk("t1_r2", 16'(rf[2]), 16'h03);

    send(ldi(1, 8'hFF), 0);
    send(ldi(2, 8'h01), 0);
    send(alu(3, 3, 1, 2), 0);
    idle(2);
    chk("t2_add", 16'(rf[3]), 16'h00);
    chk("t2_addz", 16'(zero), 16'd1);
    chk("t2_addc", 16'(carry), 16'd1);
    send(ldi(1, 8'h05), 0);
    send(ldi(2, 8'h03), 0);
    send(alu(4, 4, 2, 1), 0);
    idle(2);
    chk("t2_sub", 16'(rf[4]), 16'h00FE);
    chk("t2_subc", 16'(carry), 16'd1);
    chk("t2_subz", 16'(zero), 16'd0);

    send(ldi(5, 8'h10), 1);
    send(ldi(6, 8'h22), 1);
    send(alu(6, 7, 5, 6), 1);
    send(alu(7, 0, 7, 6), 1);
    send(alu(2, 1, 0, 0), 1);
    send(alu(5, 2, 7, 5), 1);
    idle(2);
    chk("t3_ret", 16'(retired), 16'h0E);
    chk("t3_r7", 16'(rf[7]), 16'h32);
    chk("t3_r0", 16'(rf[0]), 16'h10);
    chk("t3_r1", 16'(rf[1]), 16'h10);
    chk("t3_r2", 16'(rf[2]), 16'h10);
    chk("t3_c", 16'(carry), 16'd0);

    send(16'hB000, 0);
    idle(2);
    chk("t4_ill", 16'(illegal), 16'd1);
    chk("t4_ret", 16'(retired), 16'h0F);
    send(16'h8000, 0);
    instr = ldi(3, 8'h77);
    instr_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_halt", 16'(halted), 16'd1);
    chk("t4_rdy", 16'(instr_ready), 16'd0);
    chk("t4_hret", 16'(retired), 16'h0F);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_unhalt", 16'(halted), 16'd0);
    chk("t4_unill", 16'(illegal), 16'd0);
    chk("t4_rdy2", 16'(instr_ready), 16'd1);

    send(ldi(3, 8'h80), 0);
    send(alu(3, 4, 3, 3), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_load", 16'(Load), 16'd0);
    chk("t5_rdy", 16'(instr_ready), 16'd1);
    chk("t5_ret", 16'(retired), 16'd0);
    chk("t5_c", 16'(carry), 16'd0);
    idle(3);
    chk("t5_r4", 16'(rf[4]), 16'h00FE);

    for (int i = 0; i < 255; i++) send(16'h0000, 1);
    idle(2);
    chk("t6_ff", 16'(retired), 16'h00FF);
    send(16'h0000, 0);
    idle(2);
    chk("t6_wrap", 16'(retired), 16'h0000);
    chk("t6_r3", 16'(rf[3]), 16'h0080);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
